// File: rtl/lights_scheduler.sv
// Lights scheduler: arbitrates left/right/hazard requests and drives one
// Lights block. For each grant it holds the block in reset for one CLEAR
// cycle, then drives L/R for BLINK_CYCLES RUN cycles.
// Optional feature macro: LIGHTS_SCHED_PREEMPT_EN lets a hazard request
// preempt a running left/right grant.
module lights_scheduler #(
  parameter int unsigned BLINK_CYCLES = 8
) (
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic       ReqLeft_i,
  input  logic       ReqRight_i,
  input  logic       ReqHazard_i,
  input  logic       Cancel_i,
  output logic       L_o,
  output logic       R_o,
  output logic       LightsRst_o,
  output logic [1:0] Grant_o,
  output logic       Busy_o,
  output logic       Done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [1:0] GrantNone   = 2'b00;
  localparam logic [1:0] GrantLeft   = 2'b01;
  localparam logic [1:0] GrantRight  = 2'b10;
  localparam logic [1:0] GrantHazard = 2'b11;
  localparam logic [7:0] BlinkLoad   = BLINK_CYCLES[7:0];

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] count_q, count_d;
  logic       ptrRight_q, ptrRight_d;
  logic       lOut_q, lOut_d;
  logic       rOut_q, rOut_d;
  logic       lightsRst_q, lightsRst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] arbGrant;

  // Fixed-priority hazard, round-robin between left and right.
  // ptrRight_q set means right wins a tie.
  always_comb begin
    arbGrant = GrantNone;
    if (ReqHazard_i) begin
      arbGrant = GrantHazard;
    end else if (ReqLeft_i && ReqRight_i) begin
      arbGrant = ptrRight_q ? GrantRight : GrantLeft;
    end else if (ReqLeft_i) begin
      arbGrant = GrantLeft;
    end else if (ReqRight_i) begin
      arbGrant = GrantRight;
    end
  end

  // Next state, grant, counter, pointer and the next value of every output
  // register; outputs are derived from where the machine is going.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    count_d    = count_q;
    ptrRight_d = ptrRight_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = GrantNone;
        if (!Cancel_i && (arbGrant != GrantNone)) begin
          state_d = CLEAR;
          grant_d = arbGrant;
          count_d = BlinkLoad;
          if (arbGrant == GrantLeft) begin
            ptrRight_d = 1'b1;
          end else if (arbGrant == GrantRight) begin
            ptrRight_d = 1'b0;
          end
        end
      end

      CLEAR: begin
        if (Cancel_i) begin
          state_d = IDLE;
          grant_d = GrantNone;
          count_d = 8'd0;
        end
`ifdef LIGHTS_SCHED_PREEMPT_EN
        else if (ReqHazard_i && (grant_q != GrantHazard)) begin
          state_d = CLEAR;
          grant_d = GrantHazard;
          count_d = BlinkLoad;
        end
`endif
        else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (Cancel_i) begin
          state_d = IDLE;
          grant_d = GrantNone;
          count_d = 8'd0;
        end
`ifdef LIGHTS_SCHED_PREEMPT_EN
        else if (ReqHazard_i && (grant_q != GrantHazard)) begin
          state_d = CLEAR;
          grant_d = GrantHazard;
          count_d = BlinkLoad;
        end
`endif
        else if (count_q <= 8'd1) begin
          state_d = IDLE;
          grant_d = GrantNone;
          count_d = 8'd0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = GrantNone;
        count_d = 8'd0;
      end
    endcase

    lOut_d      = (state_d == RUN) && grant_d[0];
    rOut_d      = (state_d == RUN) && grant_d[1];
    lightsRst_d = (state_d != RUN);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q     <= IDLE;
      grant_q     <= GrantNone;
      count_q     <= 8'd0;
      ptrRight_q  <= 1'b0;
      lOut_q      <= 1'b0;
      rOut_q      <= 1'b0;
      lightsRst_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      count_q     <= count_d;
      ptrRight_q  <= ptrRight_d;
      lOut_q      <= lOut_d;
      rOut_q      <= rOut_d;
      lightsRst_q <= lightsRst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign L_o         = lOut_q;
  assign R_o         = rOut_q;
  assign LightsRst_o = lightsRst_q;
  assign Grant_o     = grant_q;
  assign Busy_o      = busy_q;
  assign Done_o      = done_q;

endmodule

// File: doc/lights_scheduler.md
LIGHTS_SCHEDULER -- requirements
Module: lights_scheduler

Interface
REQ-001 Parameter BLINK_CYCLES, default 8, number of Clk cycles one grant holds the Lights drive (legal 1..255).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 ReqLeft  input  1  level request for left sequence.
REQ-005 ReqRight  input  1  level request for right sequence.
REQ-006 ReqHazard  input  1  level request for hazard (both sides).
REQ-007 Cancel  input  1  abort current grant / suppress arbitration this cycle.
REQ-008 L  output  1  drives Lights L input.
REQ-009 R  output  1  drives Lights R input.
REQ-010 LightsRst  output  1  drives Lights Rst input.
REQ-011 Grant  output  2  00 none, 01 left, 10 right, 11 hazard.
REQ-012 Busy  output  1  high when state is not IDLE.
REQ-013 Done  output  1  one-cycle pulse on normal completion of a grant.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 States SHALL be IDLE, CLEAR, RUN; Grant register selects RUN flavour.
REQ-016 IDLE: L=0, R=0, LightsRst=1, Grant=00, Busy=0.
REQ-017 In IDLE with Cancel=0 and any request high, next state SHALL be CLEAR with Grant loaded from arbitration.
REQ-018 Arbitration: ReqHazard highest; ReqLeft vs ReqRight resolved round-robin; single requester always wins.
REQ-019 Round-robin pointer SHALL flip to the other side after each left or right grant; hazard grants leave it unchanged.
REQ-020 CLEAR SHALL last exactly one cycle: LightsRst=1, L=R=0, Busy=1, Grant held; counter loaded with BLINK_CYCLES.
REQ-021 RUN: LightsRst=0; Grant 01 -> L=1,R=0; 10 -> L=0,R=1; 11 -> L=1,R=1.
REQ-022 RUN SHALL last exactly BLINK_CYCLES cycles; counter decrements each RUN cycle; BLINK_CYCLES=1 gives one RUN cycle.
REQ-023 After final RUN cycle next state SHALL be IDLE with Done=1 for that first IDLE cycle only.
REQ-024 Latency: request high at edge N in IDLE -> CLEAR at N+1 -> first RUN cycle at N+2.
REQ-025 Requests are sampled only at arbitration; deassertion during CLEAR/RUN SHALL NOT shorten the grant.
REQ-026 Cancel in CLEAR or RUN SHALL force IDLE next cycle, no Done pulse; pointer update already made stands.
REQ-027 Cancel in IDLE SHALL block arbitration for that cycle; Cancel overrides simultaneous requests and preemption.
REQ-028 Requests held continuously SHALL re-arbitrate in the IDLE cycle after completion (one IDLE cycle minimum between grants).
REQ-029 Counter width SHALL be 8 bits; no wrap below zero.

Reset
REQ-030 Rst=1 at a rising edge SHALL set state IDLE, L=0, R=0, LightsRst=1, Grant=00, Busy=0, Done=0, counter=0, pointer=left-first.
REQ-031 Rst mid-CLEAR or mid-RUN SHALL abandon the grant with no Done pulse; Rst overrides Cancel and all requests.

Configuration
REQ-032 Macro LIGHTS_SCHED_PREEMPT_EN: when defined, ReqHazard high (Cancel=0) during CLEAR or RUN with Grant 01/10 SHALL move to CLEAR next cycle with Grant=11, counter reloaded, no Done for the preempted grant.
REQ-033 Without LIGHTS_SCHED_PREEMPT_EN, hazard SHALL wait for normal completion and win the next arbitration.
REQ-034 ReqHazard during a hazard grant SHALL have no effect in either build.

Verification
REQ-035 Rst 1 cycle, ReqLeft=1 from cycle 0, BLINK_CYCLES=8 -> CLEAR at cycle 1 (Grant=01, LightsRst=1), L=1 cycles 2-9, Done=1 cycle 10.
REQ-036 ReqLeft=ReqRight=1 held -> grants alternate 01,10,01 with 10-cycle spacing; Busy low exactly one cycle between grants.
REQ-037 ReqLeft=ReqRight=ReqHazard=1 in IDLE -> Grant=11, L=R=1 for 8 cycles, pointer unchanged (next grant still 01).
REQ-038 Left grant running, Cancel=1 at 3rd RUN cycle -> IDLE next cycle, L=0, LightsRst=1, Done stays 0.
REQ-039 Right grant at 4th RUN cycle, ReqHazard=1: with macro -> CLEAR then 8 hazard RUN cycles, single Done; without -> right completes (Done), hazard granted next.
REQ-040 Rst=1 at 5th RUN cycle -> next cycle all outputs at reset values, no Done; ReqLeft still high -> new CLEAR one cycle after Rst release.
